sdram_axi_tester: RTL and testbench
===================================

Name: sdram_axi_tester

Overview:
- AXI4 burst initiator that drives the SDRAM AXI slave port in place of the PS master.
- Write phase: fills a region with an address-derived pattern using INCR bursts.
- Read phase: reads the region back and compares every beat.
- Reports busy, done, error count and first failing address, for on-board SDRAM bring-up and regression.

Parameters:
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width (beat = DATA_W/8 bytes)
BURST_LEN, 16, beats per burst (1..256); awlen/arlen = BURST_LEN-1
CNT_W, 16, width of burst counter and error counter

Ports:
ACLK  in  1  clock
ARST  in  1  asynchronous active-high reset
start  in  1  single-cycle pulse; begins test when idle
base_addr  in  ADDR_W  start address, sampled on start, must be beat-aligned
num_bursts  in  CNT_W  bursts per phase, sampled on start
seed  in  DATA_W  pattern XOR key, sampled on start
busy  out  1  test in progress
done  out  1  sticky completion flag, cleared by next accepted start
pass  out  1  done && err_count==0
err_count  out  CNT_W  saturating mismatch/response-error count
first_err_addr  out  ADDR_W  byte address of first error
M00_AXI_aw{valid,addr,len,size,burst}  out  1/ADDR_W/8/3/2  write address channel
M00_AXI_awready  in  1
M00_AXI_w{valid,data,strb,last}  out  1/DATA_W/DATA_W/8/1  write data channel
M00_AXI_wready  in  1
M00_AXI_bvalid  in  1;  M00_AXI_bresp  in  2;  M00_AXI_bready  out  1
M00_AXI_ar{valid,addr,len,size,burst}  out  1/ADDR_W/8/3/2  read address channel
M00_AXI_arready  in  1
M00_AXI_r{valid,data,resp,last}  in  1/DATA_W/2/1;  M00_AXI_rready  out  1

Behaviour:
- Clocking and reset:
  - Single clock ACLK; ARST is asynchronous and active-high.
  - On reset: all valids, bready, rready, busy, done = 0; err_count = 0; first_err_addr = 0; FSM = IDLE.
- Fixed AXI fields:
  - size = log2(DATA_W/8); burst = 2'b01 (INCR); wstrb = all ones.
- FSM states: IDLE, WR_ADDR, WR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE.
- IDLE:
  - start with num_bursts != 0: latch inputs, clear err_count, first_err_addr and done; burst_idx = 0; go to WR_ADDR.
  - start with num_bursts == 0: go directly to DONE (done = 1 next cycle, no AXI traffic).
- Burst address = base + burst_idx*BURST_LEN*(DATA_W/8), modulo 2^ADDR_W (wrap permitted).
- Expected data for byte address A = A ^ seed (A zero-extended or truncated to DATA_W).
- WR_ADDR:
  - awvalid = 1 with awaddr/awlen stable until awready.
  - Go to WR_DATA on handshake.
- WR_DATA:
  - wvalid = 1; wdata advances only on wvalid&&wready.
  - wlast = 1 exactly on beat BURST_LEN-1.
  - After the last handshake go to WR_RESP.
  - Address and data phases are strictly serialized; no outstanding transactions.
- WR_RESP:
  - bready = 1.
  - On bvalid: bresp != 2'b00 counts one error at the burst address.
  - burst_idx++; if burst_idx == num_bursts, reset burst_idx and go to RD_ADDR; else go to WR_ADDR.
- RD_ADDR: arvalid = 1, same stability rule as WR_ADDR; go to RD_DATA on handshake.
- RD_DATA:
  - rready = 1.
  - Each rvalid beat is an error if rdata != expected, or rresp != 0, or rlast != (beat == BURST_LEN-1).
  - At most one error is counted per beat.
  - On the beat carrying rlast, or on beat BURST_LEN-1, advance the burst or go to DONE.
- Error recording:
  - err_count saturates at all ones.
  - first_err_addr is captured only when err_count == 0 before the increment.
- DONE: done = 1, busy = 0; return to IDLE in the same cycle. done remains set until the next accepted start.
- Timing:
  - busy = 1 in all states other than IDLE/DONE.
  - start while busy is ignored.
  - Minimum gap between bursts is 1 cycle (state transition).
- Reset mid-operation: channels drop immediately (asynchronous); no attempt to complete the transaction.

Optional Feature:
SDRAM_TESTER_STATS_EN
- Defined: adds outputs wr_cycles and rd_cycles (32 bits each).
  - Free-running while in the write states and read states respectively.
  - Cleared on accepted start; saturating.
  - Used for bandwidth measurement.
- Undefined: the ports and counters are absent; functionality is otherwise identical.

Decomposition:
- Shared package sdram_axi_pkg:
  - typedef of the FSM state enum.
  - AXI constants: BURST_INCR = 2'b01, RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10.
  - Function beat_bytes(DATA_W) and function size_enc(DATA_W).
- One sub-module, sdram_tester_pattern: combinational expected-data generator (addr, seed -> data), reused by the write path and read comparator.

Test Plan:
- base=0x1000, num_bursts=1, seed=0, zero-wait responder -> 16 W beats with data 0x1000..0x103C, 16 R beats; done=1, pass=1, err_count=0.
- num_bursts=4, responder flips rdata bit 0 on beat 5 of burst 2 -> err_count=1, first_err_addr=base+0x94, pass=0.
- awready/arready delayed 3 cycles, wready toggling 1/0 -> awaddr/wdata held stable while valid && !ready; exactly 16 W handshakes per burst; pass=1.
- bresp=SLVERR on burst 0, num_bursts=2 -> err_count=1, first_err_addr=base, read phase still runs.
- start with num_bursts=0 -> no valids ever asserted; done=1 one cycle after start; pass=1.
- ARST asserted during WR_DATA beat 7 -> wvalid, busy, done = 0 without waiting for a clock edge; next start runs a full, clean test.

Source files
------------

// File: rtl/sdram_axi_pkg.sv
// Shared types and AXI constants for the SDRAM AXI burst tester.
package sdram_axi_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_ADDR,
    S_WR_DATA,
    S_WR_RESP,
    S_RD_ADDR,
    S_RD_DATA,
    S_DONE
  } state_t;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  // Bytes carried by one data beat.
  function automatic int beat_bytes(input int data_w);
    return data_w / 8;
  endfunction

  // AXI AxSIZE encoding for a full-width beat.
  function automatic logic [2:0] size_enc(input int data_w);
    return 3'($clog2(data_w / 8));
  endfunction

endpackage

// File: rtl/sdram_axi_tester_if.sv
// AXI4 burst bus between the tester (master) and the SDRAM slave port.
interface sdram_axi_tester_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              awvalid;
  logic              awready;
  logic [ADDR_W-1:0] awaddr;
  logic [7:0]        awlen;
  logic [2:0]        awsize;
  logic [1:0]        awburst;

  logic                wvalid;
  logic                wready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wlast;

  logic       bvalid;
  logic       bready;
  logic [1:0] bresp;

  logic              arvalid;
  logic              arready;
  logic [ADDR_W-1:0] araddr;
  logic [7:0]        arlen;
  logic [2:0]        arsize;
  logic [1:0]        arburst;

  logic              rvalid;
  logic              rready;
  logic [DATA_W-1:0] rdata;
  logic [1:0]        rresp;
  logic              rlast;

  modport master (
    output awvalid, awaddr, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast,              input wready,
    input  bvalid, bresp,                            output bready,
    output arvalid, araddr, arlen, arsize, arburst,  input arready,
    input  rvalid, rdata, rresp, rlast,              output rready
  );

  modport slave (
    input  awvalid, awaddr, awlen, awsize, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast,              output wready,
    output bvalid, bresp,                            input  bready,
    input  arvalid, araddr, arlen, arsize, arburst,  output arready,
    output rvalid, rdata, rresp, rlast,              input  rready
  );
endinterface

// File: rtl/sdram_tester_pattern.sv
// Expected data for a byte address: address (zero-extended or truncated) XOR seed.
module sdram_tester_pattern #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] seed,
  output logic [DATA_W-1:0] data
);
  assign data = DATA_W'(addr) ^ seed;
endmodule

// File: rtl/sdram_axi_tester.sv
// SDRAM AXI4 burst tester: fills a region with an address-derived pattern,
// reads it back and counts mismatches. Optional cycle counters for bandwidth
// measurement are compiled in with `define SDRAM_TESTER_STATS_EN.
module sdram_axi_tester
  import sdram_axi_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BURST_LEN = 16,
  parameter int CNT_W     = 16
) (
  input  logic              ACLK,
  input  logic              ARST,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  num_bursts,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
`ifdef SDRAM_TESTER_STATS_EN
  output logic [31:0]       wr_cycles,
  output logic [31:0]       rd_cycles,
`endif
  sdram_axi_tester_if.master M00_AXI
);

  localparam logic [7:0]        LAST_BEAT    = 8'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] BEAT_STRIDE  = ADDR_W'(beat_bytes(DATA_W));
  localparam logic [ADDR_W-1:0] BURST_STRIDE = ADDR_W'(BURST_LEN * beat_bytes(DATA_W));

  state_t            state;
  logic [ADDR_W-1:0] base_q;
  logic [CNT_W-1:0]  nb_q;
  logic [DATA_W-1:0] seed_q;
  logic [CNT_W-1:0]  burst_idx;
  logic [CNT_W-1:0]  idx_next;
  logic [7:0]        beat_cnt;
  logic [ADDR_W-1:0] burst_addr;
  logic [ADDR_W-1:0] cur_addr;
  logic [DATA_W-1:0] exp_data;
  logic              accept;
  logic              err_event;
  logic [ADDR_W-1:0] err_addr;

  // One pattern generator serves both the write data and the read comparator,
  // since only one of the two phases is ever active.
  sdram_tester_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pattern (
    .addr (cur_addr),
    .seed (seed_q),
    .data (exp_data)
  );

  assign accept   = (state == S_IDLE) && start;
  assign idx_next = burst_idx + 1'b1;
  assign pass     = done && (err_count == '0);

  assign M00_AXI.awaddr  = burst_addr;
  assign M00_AXI.awlen   = LAST_BEAT;
  assign M00_AXI.awsize  = size_enc(DATA_W);
  assign M00_AXI.awburst = BURST_INCR;
  assign M00_AXI.wdata   = exp_data;
  assign M00_AXI.wstrb   = '1;
  assign M00_AXI.araddr  = burst_addr;
  assign M00_AXI.arlen   = LAST_BEAT;
  assign M00_AXI.arsize  = size_enc(DATA_W);
  assign M00_AXI.arburst = BURST_INCR;

  // Main sequencer: write all bursts, then read them back, with registered channel controls.
  always_ff @(posedge ACLK or posedge ARST) begin
    // NOTE: the asynchronous reset drops every valid/ready at once, so a
    // transaction in flight is abandoned rather than completed.
    if (ARST) begin
      state           <= S_IDLE;
      base_q          <= '0;
      nb_q            <= '0;
      seed_q          <= '0;
      burst_idx       <= '0;
      beat_cnt        <= '0;
      burst_addr      <= '0;
      cur_addr        <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      M00_AXI.awvalid <= 1'b0;
      M00_AXI.wvalid  <= 1'b0;
      M00_AXI.wlast   <= 1'b0;
      M00_AXI.bready  <= 1'b0;
      M00_AXI.arvalid <= 1'b0;
      M00_AXI.rready  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch sees the
      // pre-edge values of the other registers regardless of statement order.
      case (state)
        S_IDLE: begin
          if (start) begin
            base_q     <= base_addr;
            nb_q       <= num_bursts;
            seed_q     <= seed;
            burst_idx  <= '0;
            beat_cnt   <= '0;
            burst_addr <= base_addr;
            cur_addr   <= base_addr;
            if (num_bursts == '0) begin
              done  <= 1'b1;
              state <= S_DONE;
            end else begin
              done            <= 1'b0;
              busy            <= 1'b1;
              M00_AXI.awvalid <= 1'b1;
              state           <= S_WR_ADDR;
            end
          end
        end

        S_WR_ADDR: begin
          if (M00_AXI.awready) begin
            M00_AXI.awvalid <= 1'b0;
            M00_AXI.wvalid  <= 1'b1;
            M00_AXI.wlast   <= (LAST_BEAT == 8'd0);
            state           <= S_WR_DATA;
          end
        end

        S_WR_DATA: begin
          if (M00_AXI.wready) begin
            cur_addr <= cur_addr + BEAT_STRIDE;
            if (beat_cnt == LAST_BEAT) begin
              beat_cnt       <= '0;
              M00_AXI.wvalid <= 1'b0;
              M00_AXI.wlast  <= 1'b0;
              M00_AXI.bready <= 1'b1;
              state          <= S_WR_RESP;
            end else begin
              beat_cnt      <= beat_cnt + 8'd1;
              M00_AXI.wlast <= ((beat_cnt + 8'd1) == LAST_BEAT);
            end
          end
        end

        S_WR_RESP: begin
          if (M00_AXI.bvalid) begin
            M00_AXI.bready <= 1'b0;
            if (idx_next == nb_q) begin
              burst_idx       <= '0;
              burst_addr      <= base_q;
              cur_addr        <= base_q;
              M00_AXI.arvalid <= 1'b1;
              state           <= S_RD_ADDR;
            end else begin
              burst_idx       <= idx_next;
              burst_addr      <= burst_addr + BURST_STRIDE;
              cur_addr        <= burst_addr + BURST_STRIDE;
              M00_AXI.awvalid <= 1'b1;
              state           <= S_WR_ADDR;
            end
          end
        end

        S_RD_ADDR: begin
          if (M00_AXI.arready) begin
            M00_AXI.arvalid <= 1'b0;
            M00_AXI.rready  <= 1'b1;
            state           <= S_RD_DATA;
          end
        end

        S_RD_DATA: begin
          if (M00_AXI.rvalid) begin
            cur_addr <= cur_addr + BEAT_STRIDE;
            beat_cnt <= beat_cnt + 8'd1;
            // An early rlast still closes the burst; the next burst address is
            // recomputed from the burst base so a short burst cannot skew it.
            if (M00_AXI.rlast || beat_cnt == LAST_BEAT) begin
              beat_cnt       <= '0;
              M00_AXI.rready <= 1'b0;
              if (idx_next == nb_q) begin
                busy  <= 1'b0;
                done  <= 1'b1;
                state <= S_DONE;
              end else begin
                burst_idx       <= idx_next;
                burst_addr      <= burst_addr + BURST_STRIDE;
                cur_addr        <= burst_addr + BURST_STRIDE;
                M00_AXI.arvalid <= 1'b1;
                state           <= S_RD_ADDR;
              end
            end
          end
        end

        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Classify the current cycle: bad write response or bad read beat (at most one error per beat).
  always_comb begin
    // NOTE: defaults first so no path leaves these unassigned (no latch).
    err_event = 1'b0;
    err_addr  = burst_addr;
    if (state == S_WR_RESP && M00_AXI.bvalid && M00_AXI.bresp != RESP_OKAY) begin
      err_event = 1'b1;
    end
    if (state == S_RD_DATA && M00_AXI.rvalid &&
        (M00_AXI.rdata != exp_data || M00_AXI.rresp != RESP_OKAY ||
         M00_AXI.rlast != (beat_cnt == LAST_BEAT))) begin
      err_event = 1'b1;
      err_addr  = cur_addr;
    end
  end

  // Saturating error counter and first-failure address capture.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (accept) begin
      err_count      <= '0;
      first_err_addr <= '0;
    end else if (err_event) begin
      if (err_count == '0) first_err_addr <= err_addr;
      if (err_count != '1) err_count <= err_count + 1'b1;
    end
  end

`ifdef SDRAM_TESTER_STATS_EN
  // Saturating cycle counters for the write and read phases.
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      wr_cycles <= '0;
      rd_cycles <= '0;
    end else if (accept) begin
      wr_cycles <= '0;
      rd_cycles <= '0;
    end else begin
      if (state inside {S_WR_ADDR, S_WR_DATA, S_WR_RESP} && wr_cycles != '1)
        wr_cycles <= wr_cycles + 32'd1;
      if (state inside {S_RD_ADDR, S_RD_DATA} && rd_cycles != '1)
        rd_cycles <= rd_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sdram_axi_tester.sv
// Directed bench for sdram_axi_tester with a configurable AXI slave responder.
module tb_sdram_axi_tester;
  import sdram_axi_pkg::*;

  logic        ACLK = 1'b0;
  logic        ARST = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic [15:0] num_bursts = '0;
  logic [31:0] seed = '0;
  logic        busy, done, pass;
  logic [15:0] err_count;
  logic [31:0] first_err_addr;

  sdram_axi_tester_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  sdram_axi_tester #(.ADDR_W(32), .DATA_W(32), .BURST_LEN(16), .CNT_W(16)) dut (
    .ACLK           (ACLK),
    .ARST           (ARST),
    .start          (start),
    .base_addr      (base_addr),
    .num_bursts     (num_bursts),
    .seed           (seed),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .M00_AXI        (bus)
  );

  always #5 ACLK = ~ACLK;

  // Responder configuration, written only by the main process.
  int aw_delay = 0, ar_delay = 0;
  bit w_toggle = 0;
  int flip_burst = -1, flip_beat = -1, bad_bresp_burst = -1;

  // Responder state and statistics, written only by the responder.
  logic [31:0] exp_base, seed_m, wr_addr, rd_addr, first_wdata, last_wdata;
  int  aw_wait, ar_wait, aw_cnt, ar_cnt, b_cnt, w_beat, r_beat, rd_burst;
  int  w_hs, r_hs, w_bad, addr_bad, stab_bad;
  bit  b_pend, rd_active, saw_valid, wtog;
  bit  prev_awv, prev_awr, prev_wv, prev_wr, prev_arv, prev_arr;
  logic [31:0] prev_awaddr, prev_wdata, prev_araddr;

  int n_checks = 0, n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Slave model: inputs driven and outputs sampled on the falling edge; a
  // handshake is decided here and takes effect at the next rising edge.
  always @(negedge ACLK) begin
    if (ARST) begin
      bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
      bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0; bus.rlast = 0;
      aw_wait = 0; ar_wait = 0; w_beat = 0; r_beat = 0; b_pend = 0; rd_active = 0;
      prev_awv = 0; prev_wv = 0; prev_arv = 0;
    end else begin
      if (start) begin
        exp_base = base_addr; seed_m = seed;
        aw_cnt = 0; ar_cnt = 0; b_cnt = 0; w_hs = 0; r_hs = 0; w_bad = 0;
        addr_bad = 0; stab_bad = 0; saw_valid = 0; w_beat = 0; r_beat = 0;
        first_wdata = 'x; last_wdata = 'x;
      end
      if (bus.awvalid || bus.wvalid || bus.arvalid) saw_valid = 1;
      if (prev_awv && !prev_awr && (!bus.awvalid || bus.awaddr !== prev_awaddr)) stab_bad++;
      if (prev_wv && !prev_wr && (!bus.wvalid || bus.wdata !== prev_wdata)) stab_bad++;
      if (prev_arv && !prev_arr && (!bus.arvalid || bus.araddr !== prev_araddr)) stab_bad++;

      // Write response
      if (b_pend) begin
        bus.bvalid = 1;
        bus.bresp  = (b_cnt == bad_bresp_burst) ? RESP_SLVERR : RESP_OKAY;
        if (bus.bready) begin b_pend = 0; b_cnt++; end
      end else begin
        bus.bvalid = 0; bus.bresp = RESP_OKAY;
      end

      // Write data
      wtog = ~wtog;
      bus.wready = w_toggle ? wtog : 1'b1;
      if (bus.wvalid && bus.wready) begin
        if (w_hs == 0) first_wdata = bus.wdata;
        last_wdata = bus.wdata;
        w_hs++;
        if (bus.wdata !== ((wr_addr + 32'(w_beat * 4)) ^ seed_m)) w_bad++;
        if (bus.wlast !== (w_beat == 15)) w_bad++;
        if (bus.wstrb !== 4'hF) w_bad++;
        if (w_beat == 15) begin w_beat = 0; b_pend = 1; end
        else w_beat++;
      end

      // Write address
      bus.awready = 0;
      if (bus.awvalid) begin
        if (aw_wait < aw_delay) aw_wait++;
        else begin
          bus.awready = 1; aw_wait = 0; wr_addr = bus.awaddr;
          if (bus.awaddr !== exp_base + 32'(aw_cnt * 64) || bus.awlen !== 8'd15 ||
              bus.awsize !== 3'd2 || bus.awburst !== 2'b01) addr_bad++;
          aw_cnt++;
        end
      end

      // Read data
      if (rd_active) begin
        bus.rvalid = 1; bus.rresp = RESP_OKAY;
        bus.rdata  = (rd_addr + 32'(r_beat * 4)) ^ seed_m;
        if (rd_burst == flip_burst && r_beat == flip_beat) bus.rdata = bus.rdata ^ 32'h1;
        bus.rlast  = (r_beat == 15);
        if (bus.rready) begin
          r_hs++;
          if (r_beat == 15) begin r_beat = 0; rd_active = 0; end
          else r_beat++;
        end
      end else begin
        bus.rvalid = 0; bus.rlast = 0;
      end

      // Read address
      bus.arready = 0;
      if (bus.arvalid) begin
        if (ar_wait < ar_delay) ar_wait++;
        else begin
          bus.arready = 1; ar_wait = 0; rd_addr = bus.araddr;
          rd_burst = ar_cnt; rd_active = 1; r_beat = 0;
          if (bus.araddr !== exp_base + 32'(ar_cnt * 64) || bus.arlen !== 8'd15 ||
              bus.arsize !== 3'd2 || bus.arburst !== 2'b01) addr_bad++;
          ar_cnt++;
        end
      end

      prev_awv = bus.awvalid; prev_awr = bus.awready; prev_awaddr = bus.awaddr;
      prev_wv  = bus.wvalid;  prev_wr  = bus.wready;  prev_wdata  = bus.wdata;
      prev_arv = bus.arvalid; prev_arr = bus.arready; prev_araddr = bus.araddr;
    end
  end

  // Present a one-cycle start pulse; returns #1 after the accepting edge.
  task automatic kick(input logic [31:0] b, input logic [15:0] n, input logic [31:0] s);
    @(posedge ACLK); #1;
    base_addr = b; num_bursts = n; seed = s; start = 1'b1;
    @(posedge ACLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done !== 1'b1 && n < budget) begin
      @(negedge ACLK);
      n++;
    end
    check(tag, done, 1);
  endtask

  task automatic reset_cfg();
    aw_delay = 0; ar_delay = 0; w_toggle = 0;
    flip_burst = -1; flip_beat = -1; bad_bresp_burst = -1;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge ACLK);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err_count, 0);
    check("rst_first", first_err_addr, 0);
    check("rst_valids", {bus.awvalid, bus.wvalid, bus.arvalid, bus.bready, bus.rready}, 0);
    ARST = 1'b0;
    repeat (2) @(negedge ACLK);

    // 1: single burst, seed 0
    kick(32'h1000, 16'd1, 32'h0);
    check("t1_busy", busy, 1);
    check("t1_done_clr", done, 0);
    wait_done("t1_done", 500);
    check("t1_pass", pass, 1);
    check("t1_err", err_count, 0);
    check("t1_w_hs", w_hs, 16);
    check("t1_r_hs", r_hs, 16);
    check("t1_wdata_first", first_wdata, 32'h1000);
    check("t1_wdata_last", last_wdata, 32'h103C);
    check("t1_wbad", w_bad, 0);
    check("t1_addr", addr_bad, 0);

    // 2: corrupted read beat 5 of burst 2
    flip_burst = 2; flip_beat = 5;
    kick(32'h4000, 16'd4, 32'hA5A5_0000);
    wait_done("t2_done", 2000);
    check("t2_err", err_count, 1);
    check("t2_first", first_err_addr, 32'h4094);
    check("t2_pass", pass, 0);
    check("t2_busy", busy, 0);
    reset_cfg();

    // 3: slow address channels, toggling wready
    aw_delay = 3; ar_delay = 3; w_toggle = 1;
    kick(32'h3000, 16'd2, 32'h1234_5678);
    wait_done("t3_done", 2000);
    check("t3_stable", stab_bad, 0);
    check("t3_w_hs", w_hs, 32);
    check("t3_wbad", w_bad, 0);
    check("t3_aw_cnt", aw_cnt, 2);
    check("t3_addr", addr_bad, 0);
    check("t3_pass", pass, 1);
    reset_cfg();

    // 4: SLVERR on burst 0
    bad_bresp_burst = 0;
    kick(32'h8000, 16'd2, 32'h0F0F_0F0F);
    wait_done("t4_done", 2000);
    check("t4_err", err_count, 1);
    check("t4_first", first_err_addr, 32'h8000);
    check("t4_r_hs", r_hs, 32);
    check("t4_pass", pass, 0);
    reset_cfg();

    // 5: zero bursts
    kick(32'h5000, 16'd0, 32'h0);
    check("t5_done", done, 1);
    check("t5_pass", pass, 1);
    check("t5_busy", busy, 0);
    repeat (4) @(negedge ACLK);
    check("t5_no_valid", saw_valid, 0);

    // 6: reset during write beat 7, then a clean rerun
    kick(32'h2000, 16'd2, 32'hDEAD_0000);
    begin
      int n = 0;
      while (w_hs < 7 && n < 500) begin @(negedge ACLK); n++; end
      check("t6_reach_beat7", w_hs, 7);
    end
    @(posedge ACLK); #2;
    ARST = 1'b1;
    #1;
    check("t6_rst_wvalid", bus.wvalid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done", done, 0);
    repeat (2) @(negedge ACLK);
    @(posedge ACLK); #2;
    ARST = 1'b0;
    kick(32'h2000, 16'd2, 32'hDEAD_0000);
    wait_done("t6_done", 2000);
    check("t6_pass", pass, 1);
    check("t6_w_hs", w_hs, 32);
    check("t6_r_hs", r_hs, 32);
    check("t6_wbad", w_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
